// File: rtl/am2940_dma_gen.sv
// rtl/am2940_dma_gen.sv - multi-channel Am2940-style DMA address generator
// Optional per-channel address stride enabled by defining AM2940_STRIDE_EN.
module am2940_dma_gen #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        instr,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              count_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] addr,
    output logic [N_CH-1:0]   done,
    output logic              aco
);

`ifdef AM2940_STRIDE_EN
    localparam int CR_W = 6;
`else
    localparam int CR_W = 3;
`endif

    localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

    localparam logic [2:0] I_WRCR   = 3'd0;
    localparam logic [2:0] I_RDCR   = 3'd1;
    localparam logic [2:0] I_RDWC   = 3'd2;
    localparam logic [2:0] I_RDAC   = 3'd3;
    localparam logic [2:0] I_REINIT = 3'd4;
    localparam logic [2:0] I_LDAR   = 3'd5;
    localparam logic [2:0] I_LDWC   = 3'd6;
    localparam logic [2:0] I_ENCT   = 3'd7;

    logic [DATA_W-1:0] ar_r  [N_CH];
    logic [DATA_W-1:0] ac_r  [N_CH];
    logic [DATA_W-1:0] wcr_r [N_CH];
    logic [DATA_W-1:0] wc_r  [N_CH];
    logic [CR_W-1:0]   cr_r  [N_CH];
    logic [N_CH-1:0]   done_r;
    logic              aco_r;

    logic              sel_valid;
    logic [DATA_W-1:0] cur_ar, cur_ac, cur_wcr, cur_wc;
    logic [CR_W-1:0]   cur_cr;
    logic              cur_done;
    logic [1:0]        mode;
    logic              dir_dec;
    logic [DATA_W-1:0] step;
    logic [DATA_W:0]   inc_v, dec_v;

    logic [DATA_W-1:0] nxt_ar, nxt_ac, nxt_wcr, nxt_wc;
    logic [CR_W-1:0]   nxt_cr;
    logic              nxt_done;
    logic              nxt_aco;

    always_comb begin
        sel_valid = ({1'b0, ch_sel} < N_CH_L);
        cur_ar    = ar_r[ch_sel];
        cur_ac    = ac_r[ch_sel];
        cur_wcr   = wcr_r[ch_sel];
        cur_wc    = wc_r[ch_sel];
        cur_cr    = cr_r[ch_sel];
        cur_done  = done_r[ch_sel];
        mode      = cur_cr[1:0];
        dir_dec   = cur_cr[2];
`ifdef AM2940_STRIDE_EN
        step      = DATA_W'(1) << cur_cr[5:3];
`else
        step      = DATA_W'(1);
`endif
        // The extra top bit of each sum is the carry/borrow that drives aco.
        inc_v     = {1'b0, cur_ac} + {1'b0, step};
        dec_v     = {1'b0, cur_ac} - {1'b0, step};
    end

    always_comb begin
        nxt_ar   = cur_ar;
        nxt_ac   = cur_ac;
        nxt_wcr  = cur_wcr;
        nxt_wc   = cur_wc;
        nxt_cr   = cur_cr;
        nxt_done = cur_done;
        nxt_aco  = 1'b0;
        case (instr)
            I_WRCR: begin
                nxt_cr   = data_in[CR_W-1:0];
                nxt_done = 1'b0;
            end
            I_REINIT: begin
                nxt_ac   = cur_ar;
                nxt_wc   = (mode == 2'd1) ? '0 : cur_wcr;
                nxt_done = 1'b0;
            end
            I_LDAR: begin
                nxt_ar   = data_in;
                nxt_ac   = data_in;
                nxt_done = 1'b0;
            end
            I_LDWC: begin
                nxt_wcr  = data_in;
                nxt_wc   = (mode == 2'd1) ? '0 : data_in;
                nxt_done = 1'b0;
            end
            I_ENCT: begin
                if (count_en && !cur_done) begin
                    nxt_ac  = dir_dec ? dec_v[DATA_W-1:0] : inc_v[DATA_W-1:0];
                    nxt_aco = dir_dec ? dec_v[DATA_W] : inc_v[DATA_W];
                    case (mode)
                        2'd0: nxt_wc = cur_wc - 1'b1;
                        2'd1: nxt_wc = cur_wc + 1'b1;
                        2'd2: nxt_wc = cur_wc;
                        default: nxt_wc = cur_wc + 1'b1;
                    endcase
                    // Terminal test looks at the post-step values.
                    case (mode)
                        2'd0: nxt_done = (nxt_wc == '0);
                        2'd1: nxt_done = (nxt_wc == cur_wcr);
                        2'd2: nxt_done = (nxt_ac == cur_wcr);
                        default: nxt_done = (nxt_wc == '0);
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (sel_valid) begin
            case (instr)
                I_RDCR: data_out = DATA_W'(cur_cr);
                I_RDWC: data_out = cur_wc;
                I_RDAC: data_out = cur_ac;
                default: data_out = '0;
            endcase
        end
        addr = sel_valid ? cur_ac : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                ar_r[i]  <= '0;
                ac_r[i]  <= '0;
                wcr_r[i] <= '0;
                wc_r[i]  <= '0;
                cr_r[i]  <= '0;
            end
            done_r <= '0;
            aco_r  <= 1'b0;
        end else begin
            aco_r <= sel_valid & nxt_aco;
            for (int i = 0; i < N_CH; i++) begin
                if (sel_valid && ch_sel == CH_W'(i)) begin
                    ar_r[i]   <= nxt_ar;
                    ac_r[i]   <= nxt_ac;
                    wcr_r[i]  <= nxt_wcr;
                    wc_r[i]   <= nxt_wc;
                    cr_r[i]   <= nxt_cr;
                    done_r[i] <= nxt_done;
                end
            end
        end
    end

    assign done = done_r;
    assign aco  = aco_r;

endmodule
